// File: rtl/vreg_write_arbiter.sv
// ---------------------------------------------------------------------------
// vreg_write_arbiter
//
// Purpose
//   Shares the single write port of the vector register file between
//   NUM_REQ writeback sources. A round-robin arbiter grants at most one
//   requester per cycle. The granted write passes through one registered
//   output stage that drives the register file write port. An optional write
//   scoreboard tracks registers that issue has reserved but that have not yet
//   been written back. Issue logic uses it to detect read hazards.
//
// Configuration
//   VREG_WR_SCOREBOARD_EN  When defined, this macro builds the busy_mask
//                          scoreboard and the rd_hazard lookup. When it is
//                          undefined, busy_mask and rd_hazard are tied to 0,
//                          rsv_* and rd_addr are ignored, and no scoreboard
//                          flops are built.
//
// Ports
//   clk, nreset  Clock (rising edge) and asynchronous active-low reset.
//   req_valid    Per-requester valid.
//   req_ready    Per-requester accept. It is a one-hot grant with
//                same-cycle response.
//   req_addr     Per-requester destination register.
//   req_be       Per-requester lane write enables.
//   req_data     Per-requester write data.
//   rf_wr_addr   Register file write address. It is registered and held
//                while idle.
//   rf_wr_en     Register file lane enables. It is registered, and a value of
//                0 means no write.
//   rf_wr_data   Register file write data. It is registered and held while
//                idle.
//   rsv_valid    Issue reserves the destination register in rsv_addr.
//   rsv_addr     Register being reserved.
//   rd_addr      Source registers of the instruction at issue.
//   rd_hazard    Per-source flag: the source has an uncommitted reserved
//                write.
//   busy_mask    Bitmap of reserved registers.
// ---------------------------------------------------------------------------
module vreg_write_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int REG_LEN   = 64,
  parameter int NUM_REGS  = 8,
  parameter int ADDR_W    = $clog2(NUM_REGS),
  parameter int ELEM_SIZE = 8,
  parameter int BE_W      = REG_LEN / ELEM_SIZE,
  parameter int NUM_RD    = 3
) (
  input  logic                              clk,
  input  logic                              nreset,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]    req_addr,
  input  logic [NUM_REQ-1:0][BE_W-1:0]      req_be,
  input  logic [NUM_REQ-1:0][REG_LEN-1:0]   req_data,
  output logic [ADDR_W-1:0]                 rf_wr_addr,
  output logic [BE_W-1:0]                   rf_wr_en,
  output logic [REG_LEN-1:0]                rf_wr_data,
  input  logic                              rsv_valid,
  input  logic [ADDR_W-1:0]                 rsv_addr,
  input  logic [NUM_RD-1:0][ADDR_W-1:0]     rd_addr,
  output logic [NUM_RD-1:0]                 rd_hazard,
  output logic [NUM_REGS-1:0]               busy_mask
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   rr_ptr_q;
  logic [PTR_W-1:0]   rr_ptr_d;
  logic [NUM_REQ-1:0] grant_s;
  logic [PTR_W-1:0]   gnt_idx_s;
  logic               gnt_any_s;

  logic [ADDR_W-1:0]  rf_wr_addr_q;
  logic [ADDR_W-1:0]  rf_wr_addr_d;
  logic [BE_W-1:0]    rf_wr_en_q;
  logic [BE_W-1:0]    rf_wr_en_d;
  logic [REG_LEN-1:0] rf_wr_data_q;
  logic [REG_LEN-1:0] rf_wr_data_d;

  // Round-robin scan: the first valid requester at or after rr_ptr (mod NUM_REQ) wins.
  always_comb begin
    int               idx_v;
    logic [PTR_W-1:0] idx_l;
    grant_s   = '0;
    gnt_idx_s = '0;
    gnt_any_s = 1'b0;
    idx_v     = 0;
    idx_l     = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx_v = ((int'(rr_ptr_q) + off) >= NUM_REQ) ? (int'(rr_ptr_q) + off - NUM_REQ)
                                                  : (int'(rr_ptr_q) + off);
      idx_l = PTR_W'(idx_v);
      if (!gnt_any_s && req_valid[idx_l]) begin
        gnt_any_s      = 1'b1;
        grant_s[idx_l] = 1'b1;
        gnt_idx_s      = idx_l;
      end else begin
        gnt_any_s = gnt_any_s;
      end
    end
  end

  // Ready is the grant itself; it is suppressed while reset is asserted.
  always_comb begin
    if (!nreset) begin
      req_ready = '0;
    end else begin
      req_ready = grant_s;
    end
  end

  // The pointer moves to the requester just after the winner, so the winner has lowest priority next cycle.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_any_s) begin
      if (int'(gnt_idx_s) == (NUM_REQ - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = gnt_idx_s + PTR_W'(1);
      end
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Output stage: load only real writes (non-v0, non-empty enables).
  // Otherwise keep address and data and just drop the enables.
  always_comb begin
    rf_wr_en_d   = '0;
    rf_wr_addr_d = rf_wr_addr_q;
    rf_wr_data_d = rf_wr_data_q;
    if (gnt_any_s && (req_addr[gnt_idx_s] != '0) && (req_be[gnt_idx_s] != '0)) begin
      rf_wr_en_d   = req_be[gnt_idx_s];
      rf_wr_addr_d = req_addr[gnt_idx_s];
      rf_wr_data_d = req_data[gnt_idx_s];
    end else begin
      rf_wr_en_d = '0;
    end
  end

  // Arbiter pointer and output stage registers; reset discards any in-flight write.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rr_ptr_q     <= '0;
      rf_wr_en_q   <= '0;
      rf_wr_addr_q <= '0;
      rf_wr_data_q <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_wr_addr_q <= rf_wr_addr_d;
      rf_wr_data_q <= rf_wr_data_d;
    end
  end

  assign rf_wr_en   = rf_wr_en_q;
  assign rf_wr_addr = rf_wr_addr_q;
  assign rf_wr_data = rf_wr_data_q;

`ifdef VREG_WR_SCOREBOARD_EN
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // Scoreboard update. A commit clears its register as it reaches the RF.
  // A reservation applied afterwards wins, because that newer write is
  // still outstanding. v0 is never tracked.
  always_comb begin
    busy_d = busy_q;
    if (rf_wr_en_q != '0) begin
      busy_d[rf_wr_addr_q] = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    if (rsv_valid && (rsv_addr != '0)) begin
      busy_d[rsv_addr] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
    busy_d[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Hazard lookup per read port; v0 reads never hazard.
  always_comb begin
    rd_hazard = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (rd_addr[k] != '0) begin
        rd_hazard[k] = busy_q[rd_addr[k]];
      end else begin
        rd_hazard[k] = 1'b0;
      end
    end
  end

  assign busy_mask = busy_q;
`else
  logic unused_sb_inputs_s;

  assign unused_sb_inputs_s = ^{rsv_valid, rsv_addr, rd_addr};
  assign busy_mask          = '0;
  assign rd_hazard          = '0;
`endif

endmodule

// ---------------------------------------------------------------------------
// vreg_write_arbiter_chk
//
// Purpose
//   Protocol checker for the requester side of vreg_write_arbiter. It is
//   bound or instantiated alongside the arbiter. It checks three properties:
//   - A stalled request (valid && !ready) stays valid and keeps its
//     addr/be/data unchanged.
//   - The grant is one-hot or zero.
//   - Ready is asserted only towards a valid requester.
//
// Ports
//   It observes clk, nreset and the requester-side signals of the arbiter.
// ---------------------------------------------------------------------------
module vreg_write_arbiter_chk #(
  parameter int NUM_REQ  = 2,
  parameter int REG_LEN  = 64,
  parameter int ADDR_W   = 3,
  parameter int BE_W     = 8
) (
  input logic                            clk,
  input logic                            nreset,
  input logic [NUM_REQ-1:0]              req_valid,
  input logic [NUM_REQ-1:0]              req_ready,
  input logic [NUM_REQ-1:0][ADDR_W-1:0]  req_addr,
  input logic [NUM_REQ-1:0][BE_W-1:0]    req_be,
  input logic [NUM_REQ-1:0][REG_LEN-1:0] req_data
);

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    a_hold_while_stalled : assert property (@(posedge clk) disable iff (!nreset)
      (req_valid[i] && !req_ready[i]) |=>
        (req_valid[i] && $stable(req_addr[i]) && $stable(req_be[i]) && $stable(req_data[i])))
      else $error("requester %0d changed or dropped a stalled request", i);

    a_ready_needs_valid : assert property (@(posedge clk) disable iff (!nreset)
      req_ready[i] |-> req_valid[i])
      else $error("ready %0d asserted without valid", i);
  end

  a_grant_onehot : assert property (@(posedge clk) disable iff (!nreset)
    $onehot0(req_ready))
    else $error("more than one requester granted");

endmodule

// File: tb/tb_vreg_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vreg_write_arbiter
//
// Directed bench for vreg_write_arbiter with hand-computed expectations.
// Inputs change 1 time unit after a rising edge. Combinational outputs are
// read 1 unit after an input change. Registered outputs are read 1 unit
// after the edge.
// ---------------------------------------------------------------------------
module tb_vreg_write_arbiter;

  logic              clk = 1'b0;
  logic              nreset;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0][2:0]   req_addr;
  logic [1:0][7:0]   req_be;
  logic [1:0][63:0]  req_data;
  logic [2:0]        rf_wr_addr;
  logic [7:0]        rf_wr_en;
  logic [63:0]       rf_wr_data;
  logic              rsv_valid;
  logic [2:0]        rsv_addr;
  logic [2:0][2:0]   rd_addr;
  logic [2:0]        rd_hazard;
  logic [7:0]        busy_mask;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] d0 [4] = '{64'hA0A0_0000_0000_0001, 64'hA0A0_0000_0000_0002,
                          64'hA0A0_0000_0000_0003, 64'hA0A0_0000_0000_0004};
  logic [63:0] d1 [3] = '{64'hB1B1_1111_0000_0001, 64'hB1B1_1111_0000_0002,
                          64'hB1B1_1111_0000_0003};

  vreg_write_arbiter #(
    .NUM_REQ(2), .REG_LEN(64), .NUM_REGS(8), .ADDR_W(3),
    .ELEM_SIZE(8), .BE_W(8), .NUM_RD(3)
  ) u_dut (
    .clk(clk), .nreset(nreset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_be(req_be), .req_data(req_data),
    .rf_wr_addr(rf_wr_addr), .rf_wr_en(rf_wr_en), .rf_wr_data(rf_wr_data),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .rd_addr(rd_addr), .rd_hazard(rd_hazard), .busy_mask(busy_mask)
  );

  vreg_write_arbiter_chk #(
    .NUM_REQ(2), .REG_LEN(64), .ADDR_W(3), .BE_W(8)
  ) u_chk (
    .clk(clk), .nreset(nreset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_be(req_be), .req_data(req_data)
  );

  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k0;
    int k1;

    // T1: reset held with every requester valid
    nreset    = 1'b0;
    req_valid = 2'b11;
    req_addr  = '{3'd3, 3'd3};
    req_be    = '{8'hFF, 8'hFF};
    req_data  = '{64'h1111, 64'h2222};
    rsv_valid = 1'b0;
    rsv_addr  = 3'd0;
    rd_addr   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("t1_ready",   64'(req_ready),  64'(2'b00));
    check_eq("t1_wr_en",   64'(rf_wr_en),   64'(8'h00));
    check_eq("t1_wr_addr", 64'(rf_wr_addr), 64'(3'd0));
    check_eq("t1_wr_data", rf_wr_data,      64'h0);
    check_eq("t1_busy",    64'(busy_mask),  64'(8'h00));
    check_eq("t1_hazard",  64'(rd_hazard),  64'(3'b000));
    req_valid = 2'b00;
    nreset    = 1'b1;
    tick();

    // T2: single write from requester 0 (pointer 0 -> 1)
    req_valid   = 2'b01;
    req_addr[0] = 3'd3;
    req_be[0]   = 8'hFF;
    req_data[0] = 64'h0123_4567_89AB_CDEF;
    #1;
    check_eq("t2_ready", 64'(req_ready), 64'(2'b01));
    tick();
    req_valid = 2'b00;
    check_eq("t2_wr_addr", 64'(rf_wr_addr), 64'(3'd3));
    check_eq("t2_wr_en",   64'(rf_wr_en),   64'(8'hFF));
    check_eq("t2_wr_data", rf_wr_data,      64'h0123_4567_89AB_CDEF);
    tick();
    check_eq("t2_idle_en",   64'(rf_wr_en),   64'(8'h00));
    check_eq("t2_idle_addr", 64'(rf_wr_addr), 64'(3'd3));
    check_eq("t2_idle_data", rf_wr_data,      64'h0123_4567_89AB_CDEF);

    // T4a: write to v0 is accepted but never reaches the RF (pointer 1 -> 0)
    req_valid   = 2'b10;
    req_addr[1] = 3'd0;
    req_be[1]   = 8'hFF;
    req_data[1] = 64'hDEAD_BEEF;
    #1;
    check_eq("t4_v0_ready", 64'(req_ready), 64'(2'b10));
    tick();
    req_valid = 2'b00;
    check_eq("t4_v0_en",   64'(rf_wr_en),   64'(8'h00));
    check_eq("t4_v0_addr", 64'(rf_wr_addr), 64'(3'd3));

    // T3: both requesters continuously valid -> grants alternate 0,1,0,1,0,1
    // and then 0 once more to drain requester 0's last item.
    k0 = 0;
    k1 = 0;
    req_addr[0] = 3'd1;
    req_addr[1] = 3'd2;
    req_be      = '{8'hFF, 8'hFF};
    req_data[0] = d0[0];
    req_data[1] = d1[0];
    req_valid   = 2'b11;
    for (int c = 0; c < 7; c++) begin
      #1;
      check_eq("t3_ready", 64'(req_ready), (c % 2 == 0) ? 64'h1 : 64'h2);
      tick();
      if (c % 2 == 0) begin
        check_eq("t3_data0", rf_wr_data,      d0[k0]);
        check_eq("t3_addr0", 64'(rf_wr_addr), 64'(3'd1));
        k0++;
        if (k0 < 4) req_data[0] = d0[k0];
        else        req_valid[0] = 1'b0;
      end else begin
        check_eq("t3_data1", rf_wr_data,      d1[k1]);
        check_eq("t3_addr1", 64'(rf_wr_addr), 64'(3'd2));
        k1++;
        if (k1 < 3) req_data[1] = d1[k1];
        else        req_valid[1] = 1'b0;
      end
    end

    // T4b: zero byte enables are accepted but produce no write (pointer 1 -> 1)
    req_valid   = 2'b01;
    req_addr[0] = 3'd5;
    req_be[0]   = 8'h00;
    req_data[0] = 64'h5555_5555;
    #1;
    check_eq("t4_be0_ready", 64'(req_ready), 64'(2'b01));
    tick();
    req_valid = 2'b00;
    check_eq("t4_be0_en",   64'(rf_wr_en),   64'(8'h00));
    check_eq("t4_be0_addr", 64'(rf_wr_addr), 64'(3'd1));
    check_eq("t4_be0_data", rf_wr_data,      d0[3]);

`ifdef VREG_WR_SCOREBOARD_EN
    // T5: reserve v4, observe hazard, commit clears it
    rsv_valid = 1'b1;
    rsv_addr  = 3'd4;
    tick();
    rsv_valid = 1'b0;
    check_eq("t5_busy_set", 64'(busy_mask), 64'(8'h10));
    rd_addr[1] = 3'd4;
    #1;
    check_eq("t5_hazard_set", 64'(rd_hazard), 64'(3'b010));
    req_valid   = 2'b01;
    req_addr[0] = 3'd4;
    req_be[0]   = 8'h0F;
    req_data[0] = 64'h4444_4444;
    #1;
    check_eq("t5_ready", 64'(req_ready), 64'(2'b01));
    tick();
    req_valid = 2'b00;
    check_eq("t5_wr_en",       64'(rf_wr_en),  64'(8'h0F));
    check_eq("t5_busy_pend",   64'(busy_mask), 64'(8'h10));
    check_eq("t5_hazard_pend", 64'(rd_hazard), 64'(3'b010));
    tick();
    check_eq("t5_busy_clr",   64'(busy_mask), 64'(8'h00));
    check_eq("t5_hazard_clr", 64'(rd_hazard), 64'(3'b000));

    // T6: commit to v6 on the same edge as a new reservation of v6 -> stays busy
    req_valid   = 2'b10;
    req_addr[1] = 3'd6;
    req_be[1]   = 8'hFF;
    req_data[1] = 64'h6666_6666;
    #1;
    check_eq("t6_ready", 64'(req_ready), 64'(2'b10));
    tick();
    req_valid = 2'b00;
    check_eq("t6_wr_en",     64'(rf_wr_en),  64'(8'hFF));
    check_eq("t6_busy_pre",  64'(busy_mask), 64'(8'h00));
    rsv_valid = 1'b1;
    rsv_addr  = 3'd6;
    tick();
    rsv_valid = 1'b0;
    check_eq("t6_busy_setwins", 64'(busy_mask), 64'(8'h40));
`else
    // Scoreboard absent: reservations and reads have no effect
    rsv_valid  = 1'b1;
    rsv_addr   = 3'd4;
    rd_addr    = '{3'd4, 3'd4, 3'd4};
    tick();
    rsv_valid = 1'b0;
    check_eq("nosb_busy", 64'(busy_mask), 64'(8'h00));
    #1;
    check_eq("nosb_hazard", 64'(rd_hazard), 64'(3'b000));
    rd_addr = '0;
    rd_addr[1] = 3'd4;
`endif

    // T6: reset in the middle of traffic
    req_valid   = 2'b01;
    req_addr[0] = 3'd7;
    req_be[0]   = 8'hFF;
    req_data[0] = 64'h7777_7777;
    rsv_valid   = 1'b1;
    rsv_addr    = 3'd2;
    #1;
    check_eq("t6r_ready", 64'(req_ready), 64'(2'b01));
    tick();
    rsv_valid = 1'b0;
    check_eq("t6r_inflight_en", 64'(rf_wr_en), 64'(8'hFF));
`ifdef VREG_WR_SCOREBOARD_EN
    check_eq("t6r_busy_pre", 64'(busy_mask), 64'(8'h44));
`endif
    req_valid   = 2'b11;
    req_addr    = '{3'd3, 3'd2};
    req_data    = '{64'hCCCC_0003, 64'hCCCC_0002};
    req_be      = '{8'hFF, 8'hFF};
    nreset      = 1'b0;
    #1;
    check_eq("t6r_rst_en",     64'(rf_wr_en),   64'(8'h00));
    check_eq("t6r_rst_busy",   64'(busy_mask),  64'(8'h00));
    check_eq("t6r_rst_ready",  64'(req_ready),  64'(2'b00));
    check_eq("t6r_rst_addr",   64'(rf_wr_addr), 64'(3'd0));
    check_eq("t6r_rst_hazard", 64'(rd_hazard),  64'(3'b000));
    tick();
    check_eq("t6r_rst_en2", 64'(rf_wr_en), 64'(8'h00));
    nreset = 1'b1;
    #1;
    // Pointer was 1 before reset; after reset requester 0 must win.
    check_eq("t6r_ptr_reset", 64'(req_ready), 64'(2'b01));
    tick();
    req_valid[0] = 1'b0;
    check_eq("t6r_post_addr", 64'(rf_wr_addr), 64'(3'd2));
    check_eq("t6r_post_data", rf_wr_data,      64'hCCCC_0002);
    #1;
    check_eq("t6r_next_ready", 64'(req_ready), 64'(2'b10));
    tick();
    req_valid = 2'b00;
    check_eq("t6r_post_addr1", 64'(rf_wr_addr), 64'(3'd3));
    check_eq("t6r_post_en1",   64'(rf_wr_en),   64'(8'hFF));
    tick();
    check_eq("t6r_final_idle", 64'(rf_wr_en), 64'(8'h00));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
